maxpool_2x2_6_channel: RTL and testbench
========================================

Name: maxpool_2x2_6_channel

Overview:
- Streaming 2x2 max-pool, stride 2, applied independently to 6 channels.
- Sits directly downstream of the 6-output 1x1 convolution layer and consumes its Out_0..Out_5 / valid_out stream.
- Reduces an IMG_Width x IMG_Height feature map to floor(W/2) x floor(H/2).
- Output handshake style (valid-only, no backpressure) matches the conv stages, so the block chains directly into the next conv layer.

Parameters:
- IMG_Width, 4, input feature-map width in pixels (>=2).
- IMG_Height, 4, input feature-map height in pixels (>=2).
- Datawidth, 32, bits per channel sample.
- Compare_FP, 1, 1 = samples are IEEE-754 binary32 and are compared as floats; 0 = samples are signed two's-complement and are compared as integers.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- valid_in  input  1  In_0..In_5 carry one pixel (all 6 channels) this cycle.
- In_0..In_5  input  Datawidth each  channel samples, raster order (row-major, column 0 first).
- valid_out  output  1  Out_0..Out_5 carry one pooled pixel this cycle.
- Out_0..Out_5  output  Datawidth each  pooled channel samples, raster order of the pooled map.

Behaviour:
- Reset: rst is synchronous, active-high, and clocked on clk.
  - While rst is high: valid_out=0, Out_0..Out_5=0, column and row counters=0, horizontal-hold registers=0, line buffer contents are don't-care.
  - Reset mid-frame abandons the partial frame. The first valid_in after reset is pixel (row 0, col 0).
- Counters: col (0..IMG_Width-1) and row (0..IMG_Height-1) advance only on valid_in.
  - col wraps to 0 at IMG_Width-1 and row increments.
  - At (IMG_Height-1, IMG_Width-1), both counters wrap to 0, and the next frame starts with no idle cycle required.
- valid_in gaps of any length are allowed. State holds during gaps.
- Datapath, per channel, evaluated on valid_in:
  - Even col: cur is stored in a hold register h.
  - Odd col, even row: line buffer entry lb[col>>1] <= max(h, cur).
  - Odd col, odd row: result = max(lb[col>>1], max(h, cur)) is registered to Out_k, and valid_out=1 on the next clock edge.
- Latency: valid_out rises exactly 1 cycle after the valid_in that delivers the bottom-right pixel of a 2x2 window.
  - valid_out is a 1-cycle pulse per pooled pixel.
  - valid_out=0 on all other cycles.
  - Out_k holds its last value while valid_out=0.
- Odd dimensions: when IMG_Width is odd, the last column of each row is consumed (counter advances) but never pooled. When IMG_Height is odd, the last row is consumed but never pooled. This gives floor semantics.
- Line buffer: floor(IMG_Width/2) entries x 6 channels x Datawidth. Inferable as registers or distributed RAM.
- Compare rule:
  - Compare_FP=0: signed compare of the full Datawidth.
  - Compare_FP=1: map x to key = x[31] ? ~x : x^0x80000000, then compare keys as unsigned. This gives total ordering, with -0.0 < +0.0.
  - NaN inputs are not expected; the result is defined by the key ordering.
- Ties: the earlier operand (h, or lb) is selected. Results are bit-exact copies of one input; no arithmetic is performed.
- Throughput: one pixel per cycle sustained, with no stalls. The block has no ready signal, and the upstream stage never waits.

Test Plan:
- Integer mode (Compare_FP=0), 4x4, channel k = pixel index + 16k, all 6 channels, continuous valid_in:
  - Expect exactly 4 valid_out pulses, each 1 cycle after the inputs at (1,1), (1,3), (3,1), (3,3).
  - Out_0 = 5, 7, 13, 15; Out_5 = 85, 87, 93, 95.
- FP mode, 2x2 window of -2.0 (0xC0000000), -1.0 (0xBF800000), -3.0 (0xC0400000), -0.0 (0x80000000):
  - Out = 0x80000000.
  - A second window with all values 0x3F800000 except one 0x40000000 gives Out = 0x40000000.
- Odd size 5x3, integer mode, values = pixel index:
  - Expect 2 pulses only, Out_0 = 6, then 8.
  - Column 4 and row 2 are never emitted, and the counters wrap correctly into the next frame.
- Random valid_in gaps (0-5 idle cycles) on a 4x4 frame:
  - Outputs and ordering are identical to the continuous case.
  - Each valid_out follows its completing valid_in by exactly 1 cycle.
- Reset asserted after 6 pixels of a 4x4 frame, then a fresh full frame is sent:
  - During reset, valid_out=0 and Out_k=0.
  - The fresh frame produces exactly 4 correct pulses, with no leftover data from the partial frame.
- Two back-to-back 4x4 frames with no idle cycle:
  - 8 pulses are produced, and the second frame's results are independent of the first frame's line-buffer contents.

Source files
------------

// File: rtl/maxpool_2x2_6_channel.sv
// Streaming 2x2 / stride-2 max-pool over 6 independent channels.
// Valid-only handshake, one pixel per cycle, no backpressure.
// Odd trailing columns and rows are consumed but never pooled (floor semantics).
module maxpool_2x2_6_channel #(
    parameter int IMG_Width  = 4,
    parameter int IMG_Height = 4,
    parameter int Datawidth  = 32,
    parameter int Compare_FP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In_0,
    input  logic [Datawidth-1:0] In_1,
    input  logic [Datawidth-1:0] In_2,
    input  logic [Datawidth-1:0] In_3,
    input  logic [Datawidth-1:0] In_4,
    input  logic [Datawidth-1:0] In_5,
    output logic                 valid_out,
    output logic [Datawidth-1:0] Out_0,
    output logic [Datawidth-1:0] Out_1,
    output logic [Datawidth-1:0] Out_2,
    output logic [Datawidth-1:0] Out_3,
    output logic [Datawidth-1:0] Out_4,
    output logic [Datawidth-1:0] Out_5
);

    localparam int unsigned NCH  = 6;
    localparam int unsigned LB_N = IMG_Width / 2;
    localparam int unsigned CW   = $clog2(IMG_Width);
    localparam int unsigned RW   = $clog2(IMG_Height);
    localparam int unsigned LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic                 r_valid;
    logic [Datawidth-1:0] r_hold [NCH];
    logic [Datawidth-1:0] r_out  [NCH];
    logic [Datawidth-1:0] r_lb   [LB_N][NCH];

    logic [Datawidth-1:0] w_in   [NCH];
    logic [Datawidth-1:0] w_pair [NCH];
    logic [Datawidth-1:0] w_quad [NCH];
    logic [LBW-1:0]       w_lb_idx;
    logic                 w_col_last;
    logic                 w_row_last;

    // Order-preserving unsigned key for IEEE-754 bit patterns (-0.0 sorts below +0.0)
    function automatic logic [Datawidth-1:0] f_key(input logic [Datawidth-1:0] x);
        return x[Datawidth-1] ? ~x : (x ^ {1'b1, {(Datawidth-1){1'b0}}});
    endfunction

    // Larger of two samples; on a tie the earlier operand a wins
    function automatic logic [Datawidth-1:0] f_max(input logic [Datawidth-1:0] a,
                                                   input logic [Datawidth-1:0] b);
        logic b_gt;
        if (Compare_FP != 0) b_gt = f_key(b) > f_key(a);
        else                 b_gt = $signed(b) > $signed(a);
        return b_gt ? b : a;
    endfunction

    assign w_in[0] = In_0;
    assign w_in[1] = In_1;
    assign w_in[2] = In_2;
    assign w_in[3] = In_3;
    assign w_in[4] = In_4;
    assign w_in[5] = In_5;

    assign w_lb_idx   = LBW'(r_col >> 1);
    assign w_col_last = (r_col == CW'(IMG_Width - 1));
    assign w_row_last = (r_row == RW'(IMG_Height - 1));

    // Horizontal pair max and full 2x2 window max per channel
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_pair[k] = f_max(r_hold[k], w_in[k]);
            w_quad[k] = f_max(r_lb[w_lb_idx][k], w_pair[k]);
        end
    end

    // Raster counters, horizontal hold, pooled output and valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_hold[k] <= '0;
                r_out[k]  <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            if (valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                for (int k = 0; k < NCH; k++) begin
                    if (!r_col[0])     r_hold[k] <= w_in[k];
                    else if (r_row[0]) r_out[k]  <= w_quad[k];
                end
                r_valid <= r_col[0] & r_row[0];
            end
        end
    end

    // Line buffer holds the top-row pair max for each pooled column
    always_ff @(posedge clk) begin
        if (valid_in && r_col[0] && !r_row[0]) begin
            for (int k = 0; k < NCH; k++) r_lb[w_lb_idx][k] <= w_pair[k];
        end
    end

    assign valid_out = r_valid;
    assign Out_0     = r_out[0];
    assign Out_1     = r_out[1];
    assign Out_2     = r_out[2];
    assign Out_3     = r_out[3];
    assign Out_4     = r_out[4];
    assign Out_5     = r_out[5];

endmodule

// File: tb/tb_maxpool_2x2_6_channel.sv
// Bench for maxpool_2x2_6_channel: three instances (4x4 integer, 2x2 float, 5x3 integer)
// checked against a frame-level reference model and a timestamped scoreboard.
module tb_maxpool_2x2_6_channel;

    localparam int W  [3] = '{4, 2, 5};
    localparam int H  [3] = '{4, 2, 3};
    localparam int FP [3] = '{0, 1, 0};

    typedef struct {
        int               inst;
        logic [5:0][31:0] d;
        int               cyc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [2:0]             tv  = '0;
    logic [2:0][5:0][31:0]  tin = '0;
    wire  [5:0][31:0]       o0, o1, o2;
    wire                    vo0, vo1, vo2;

    int               cyc    = 0;
    int               n_chk  = 0;
    int               n_fail = 0;
    int               np [3] = '{0, 0, 0};
    int               mr [3] = '{0, 0, 0};
    int               mc [3] = '{0, 0, 0};
    logic [5:0][31:0] fr [3][8][8];
    exp_t             q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool_2x2_6_channel #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .Compare_FP(0)) u_int44 (
        .clk(clk), .rst(rst), .valid_in(tv[0]),
        .In_0(tin[0][0]), .In_1(tin[0][1]), .In_2(tin[0][2]),
        .In_3(tin[0][3]), .In_4(tin[0][4]), .In_5(tin[0][5]),
        .valid_out(vo0),
        .Out_0(o0[0]), .Out_1(o0[1]), .Out_2(o0[2]),
        .Out_3(o0[3]), .Out_4(o0[4]), .Out_5(o0[5]));

    maxpool_2x2_6_channel #(.IMG_Width(2), .IMG_Height(2), .Datawidth(32), .Compare_FP(1)) u_fp22 (
        .clk(clk), .rst(rst), .valid_in(tv[1]),
        .In_0(tin[1][0]), .In_1(tin[1][1]), .In_2(tin[1][2]),
        .In_3(tin[1][3]), .In_4(tin[1][4]), .In_5(tin[1][5]),
        .valid_out(vo1),
        .Out_0(o1[0]), .Out_1(o1[1]), .Out_2(o1[2]),
        .Out_3(o1[3]), .Out_4(o1[4]), .Out_5(o1[5]));

    maxpool_2x2_6_channel #(.IMG_Width(5), .IMG_Height(3), .Datawidth(32), .Compare_FP(0)) u_int53 (
        .clk(clk), .rst(rst), .valid_in(tv[2]),
        .In_0(tin[2][0]), .In_1(tin[2][1]), .In_2(tin[2][2]),
        .In_3(tin[2][3]), .In_4(tin[2][4]), .In_5(tin[2][5]),
        .valid_out(vo2),
        .Out_0(o2[0]), .Out_1(o2[1]), .Out_2(o2[2]),
        .Out_3(o2[3]), .Out_4(o2[4]), .Out_5(o2[5]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference ordering: signed integers, or IEEE-754 total order on the bit pattern
    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b, input int fp);
        logic [31:0] ka, kb;
        if (fp != 0) begin
            ka = a[31] ? ~a : a ^ 32'h8000_0000;
            kb = b[31] ? ~b : b ^ 32'h8000_0000;
            return (kb > ka) ? b : a;
        end
        return ($signed(b) > $signed(a)) ? b : a;
    endfunction

    function automatic logic [5:0][31:0] outs(input int i);
        case (i)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    function automatic logic vout(input int i);
        case (i)
            0:       return vo0;
            1:       return vo1;
            default: return vo2;
        endcase
    endfunction

    task automatic pulse(input int i, input logic [5:0][31:0] d);
        exp_t e;
        np[i]++;
        check("pulse_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pulse_inst", 32'(i), 32'(e.inst));
            check("pulse_latency", 32'(cyc), 32'(e.cyc));
            for (int k = 0; k < 6; k++) check($sformatf("out%0d_ch%0d", i, k), d[k], e.d[k]);
        end
    endtask

    always @(negedge clk) begin
        if (vo0 === 1'b1) pulse(0, o0);
        if (vo1 === 1'b1) pulse(1, o1);
        if (vo2 === 1'b1) pulse(2, o2);
    end

    // Drive one pixel after an idle gap; record it in the frame and predict any completed window
    task automatic send(input int i, input logic [5:0][31:0] v, input int gap);
        exp_t e;
        int r, c;
        tv = '0;
        repeat (gap) begin @(posedge clk); #1; end
        r = mr[i];
        c = mc[i];
        tin[i] = v;
        tv[i]  = 1'b1;
        fr[i][r][c] = v;
        if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (H[i] / 2)) && (c < 2 * (W[i] / 2))) begin
            e.inst = i;
            e.cyc  = cyc + 1;
            for (int k = 0; k < 6; k++)
                e.d[k] = ref_max(ref_max(ref_max(fr[i][r-1][c-1][k], fr[i][r-1][c][k], FP[i]),
                                         fr[i][r][c-1][k], FP[i]), fr[i][r][c][k], FP[i]);
            q.push_back(e);
        end
        mc[i] = c + 1;
        if (mc[i] == W[i]) begin
            mc[i] = 0;
            mr[i] = (r + 1 == H[i]) ? 0 : r + 1;
        end
        @(posedge clk); #1;
        tv[i] = 1'b0;
    endtask

    // One frame: mode 0 = channel k carries pixel_index + 16k, mode 1 = random samples
    task automatic frame(input int i, input int mode, input int maxgap);
        logic [5:0][31:0] v;
        for (int p = 0; p < W[i] * H[i]; p++) begin
            for (int k = 0; k < 6; k++) v[k] = (mode == 0) ? 32'(p + 16 * k) : $urandom;
            send(i, v, (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
        end
    endtask

    task automatic settle(input string tag);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(vout(i)), 32'd0);
            for (int k = 0; k < 6; k++) check($sformatf("%s_out%0d_ch%0d", tag, i, k), outs(i)[k], 32'd0);
        end
    endtask

    task automatic do_reset();
        tv  = '0;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("in_reset");
        end
        check("reset_queue", 32'(q.size()), 32'd0);
        q.delete();
        for (int i = 0; i < 3; i++) begin mr[i] = 0; mc[i] = 0; end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int s;
        int pos;
        logic [5:0][31:0] v;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Integer 4x4, index pattern, continuous valid_in
        s = np[0];
        frame(0, 0, 0);
        settle("int44");
        check("int44_pulses", 32'(np[0] - s), 32'd4);
        check("int44_last_ch0", o0[0], 32'd15);
        check("int44_last_ch5", o0[5], 32'd95);
        check("int44_hold_valid", 32'(vo0), 32'd0);

        // Float window with negative values and -0.0
        send(1, {6{32'hC000_0000}}, 0);
        send(1, {6{32'hBF80_0000}}, 0);
        send(1, {6{32'hC040_0000}}, 0);
        send(1, {6{32'h8000_0000}}, 0);
        settle("fp_neg");
        check("fp_neg_zero", o1[0], 32'h8000_0000);

        // Float window: single 2.0 among 1.0 at a random position
        pos = $urandom_range(3, 0);
        for (int p = 0; p < 4; p++) send(1, (p == pos) ? {6{32'h4000_0000}} : {6{32'h3F80_0000}}, 0);
        settle("fp_two");
        check("fp_two", o1[3], 32'h4000_0000);

        // Float random windows with gaps
        s = np[1];
        for (int f = 0; f < 4; f++) frame(1, 1, 3);
        settle("fp_rand");
        check("fp_rand_pulses", 32'(np[1] - s), 32'd4);

        // Odd 5x3 integer, two frames back to back
        s = np[2];
        frame(2, 0, 0);
        settle("odd53_f1");
        check("odd53_f1_last", o2[0], 32'd8);
        frame(2, 0, 0);
        settle("odd53_f2");
        check("odd53_pulses", 32'(np[2] - s), 32'd4);

        // Integer 4x4 random values with random 0..5 idle gaps
        s = np[0];
        frame(0, 1, 5);
        frame(0, 1, 5);
        settle("gaps");
        check("gaps_pulses", 32'(np[0] - s), 32'd8);

        // Reset after 6 pixels, then a fresh frame
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 6; k++) v[k] = $urandom;
            send(0, v, 0);
        end
        do_reset();
        s = np[0];
        frame(0, 1, 0);
        settle("after_reset");
        check("after_reset_pulses", 32'(np[0] - s), 32'd4);

        // Two back-to-back random frames
        s = np[0];
        frame(0, 1, 0);
        frame(0, 1, 0);
        settle("b2b");
        check("b2b_pulses", 32'(np[0] - s), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
